// File: rtl/mem_stage_if.sv
// Shared pipeline bus types (package core) and the data-memory req/gnt/rvalid
// interface; mem_stage drives the master modport, the memory the slave side.
package core;

  typedef enum logic [3:0] {
    MEM_NOP,
    MEM_LB,
    MEM_LH,
    MEM_LW,
    MEM_LBU,
    MEM_LHU,
    MEM_SB,
    MEM_SH,
    MEM_SW
  } mem_op_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [31:0] rd_res;
    logic [31:0] rs2_data;
    mem_op_t     mem_op;
  } pipeline_bus_t;

endpackage

interface mem_stage_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [3:0]            be;
  logic [31:0]           wdata;
  logic                  gnt;
  logic                  rvalid;
  logic [31:0]           rdata;

  modport master (
    output req, we, addr, be, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/mem_stage.sv
// Pipeline memory-access stage: issues loads/stores over the mem_stage_if handshake.
// Optional misaligned-access trap enabled by defining MEM_MISALIGN_CHECK_EN.
module mem_stage
  import core::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_WIDTH     = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  pipeline_bus_t bus_i,
  output logic          stall_o,
  output pipeline_bus_t bus_o,
  output logic          valid_o,
  mem_stage_if.master   dmem,
  output logic          bus_err_o,
  output logic          misalign_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP} state_t;

  state_t        state;
  pipeline_bus_t hold;
  pipeline_bus_t ret_zero;
  pipeline_bus_t ret_load;
  logic [31:0]   tmo_cnt;
  logic          timeout_hit;

  function automatic logic is_store(mem_op_t op);
    return op inside {MEM_SB, MEM_SH, MEM_SW};
  endfunction

  function automatic logic [3:0] lane_be(mem_op_t op, logic [1:0] a);
    case (op)
      MEM_LB, MEM_LBU, MEM_SB: lane_be = 4'b0001 << a;
      MEM_LH, MEM_LHU, MEM_SH: lane_be = 4'b0011 << {a[1], 1'b0};
      default:                 lane_be = 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] store_data(mem_op_t op, logic [31:0] rs2);
    case (op)
      MEM_SB:  store_data = {4{rs2[7:0]}};
      MEM_SH:  store_data = {2{rs2[15:0]}};
      MEM_SW:  store_data = rs2;
      default: store_data = '0;
    endcase
  endfunction

  function automatic logic [31:0] load_value(mem_op_t op, logic [1:0] a, logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(d >> {a, 3'b000});
    h = a[1] ? d[31:16] : d[15:0];
    case (op)
      MEM_LB:  load_value = {{24{b[7]}}, b};
      MEM_LBU: load_value = {24'h0, b};
      MEM_LH:  load_value = {{16{h[15]}}, h};
      MEM_LHU: load_value = {16'h0, h};
      default: load_value = d;
    endcase
  endfunction

`ifdef MEM_MISALIGN_CHECK_EN
  pipeline_bus_t in_zero;

  function automatic logic misaligned(mem_op_t op, logic [1:0] a);
    case (op)
      MEM_LH, MEM_LHU, MEM_SH: misaligned = a[0];
      MEM_LW, MEM_SW:          misaligned = (a != 2'b00);
      default:                 misaligned = 1'b0;
    endcase
  endfunction

  always_comb begin
    in_zero        = bus_i;
    in_zero.rd_res = '0;
  end
`else
  assign misalign_o = 1'b0;
`endif

  assign stall_o = (state != IDLE);

  // ">=" so an access granted exactly at the limit still times out in WAIT_RSP
  always_comb begin
    ret_zero        = hold;
    ret_zero.rd_res = '0;
    ret_load        = hold;
    ret_load.rd_res = load_value(hold.mem_op, hold.rd_res[1:0], dmem.rdata);
    timeout_hit     = (TIMEOUT_CYCLES != 0) && (tmo_cnt >= 32'(TIMEOUT_CYCLES - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      hold       <= '0;
      bus_o      <= '0;
      valid_o    <= 1'b0;
      dmem.req   <= 1'b0;
      dmem.we    <= 1'b0;
      dmem.addr  <= '0;
      dmem.be    <= '0;
      dmem.wdata <= '0;
      bus_err_o  <= 1'b0;
      tmo_cnt    <= '0;
`ifdef MEM_MISALIGN_CHECK_EN
      misalign_o <= 1'b0;
`endif
    end else begin
      valid_o   <= 1'b0;
      bus_err_o <= 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
      misalign_o <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (bus_i.mem_op == MEM_NOP) begin
            bus_o   <= bus_i;
            valid_o <= 1'b1;
          end
`ifdef MEM_MISALIGN_CHECK_EN
          else if (misaligned(bus_i.mem_op, bus_i.rd_res[1:0])) begin
            bus_o      <= in_zero;
            valid_o    <= 1'b1;
            misalign_o <= 1'b1;
          end
`endif
          else begin
            hold       <= bus_i;
            dmem.req   <= 1'b1;
            dmem.we    <= is_store(bus_i.mem_op);
            dmem.addr  <= {bus_i.rd_res[ADDR_WIDTH-1:2], 2'b00};
            dmem.be    <= lane_be(bus_i.mem_op, bus_i.rd_res[1:0]);
            dmem.wdata <= store_data(bus_i.mem_op, bus_i.rs2_data);
            tmo_cnt    <= '0;
            state      <= REQ;
          end
        end

        REQ: begin
          tmo_cnt <= tmo_cnt + 32'd1;
          if (dmem.gnt) begin
            dmem.req <= 1'b0;
            if (is_store(hold.mem_op)) begin
              bus_o   <= hold;
              valid_o <= 1'b1;
              state   <= IDLE;
            end else begin
              state <= WAIT_RSP;
            end
          end else if (timeout_hit) begin
            dmem.req  <= 1'b0;
            bus_err_o <= 1'b1;
            bus_o     <= ret_zero;
            valid_o   <= 1'b1;
            state     <= IDLE;
          end
        end

        WAIT_RSP: begin
          tmo_cnt <= tmo_cnt + 32'd1;
          if (dmem.rvalid) begin
            bus_o   <= ret_load;
            valid_o <= 1'b1;
            state   <= IDLE;
          end else if (timeout_hit) begin
            bus_err_o <= 1'b1;
            bus_o     <= ret_zero;
            valid_o   <= 1'b1;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
